// File: rtl/seg_disp_arb_pkg.sv
// ============================================================================
// Module  : seg_disp_arb_pkg
// Brief   : Shared FSM states, segment constants and magnitude-to-segment table
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg_disp_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hFD;

  // Active-low {a,b,c,d,e,f,g,dp}; dp is never lit.
  function automatic logic [7:0] mag_to_seg(input logic [3:0] mag);
    logic [7:0] seg;
    case (mag)
      4'd0:    seg = 8'h03;
      4'd1:    seg = 8'h9F;
      4'd2:    seg = 8'h25;
      4'd3:    seg = 8'h0D;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h49;
      4'd6:    seg = 8'h41;
      4'd7:    seg = 8'h1F;
      4'd8:    seg = 8'h01;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_enc4.sv
// ============================================================================
// Module  : seg_enc4
// Brief   : 4-bit signed value to {sign digit, magnitude digit} segment patterns
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_enc4
  import seg_disp_arb_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] sign_seg,
  output logic [7:0] mag_seg
);

  logic       w_neg;
  logic [3:0] w_mag;

  // Unsigned 4-bit negation maps -8 (1000) onto magnitude 8.
  assign w_neg    = value[3];
  assign w_mag    = w_neg ? (~value + 4'd1) : value;
  assign sign_seg = w_neg ? SEG_MINUS : SEG_BLANK;
  assign mag_seg  = mag_to_seg(w_mag);

endmodule

`default_nettype wire

// File: rtl/seg_disp_arb.sv
// ============================================================================
// Module  : seg_disp_arb
// Brief   : Two-requester round-robin arbiter driving a scanned 2-digit display
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_disp_arb
  import seg_disp_arb_pkg::*;
#(
  parameter int DWELL_CYC = 16,
  parameter int SCAN_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [3:0] req_val0,
  input  logic [3:0] req_val1,
  output logic [1:0] req_ready,
  output logic [7:0] seg_out,
  output logic [1:0] an_n,
  output logic       owner,
  output logic       busy
);

  localparam logic [7:0] c_dwell_last = 8'(DWELL_CYC - 1);
  localparam logic [7:0] c_scan_last  = 8'(SCAN_DIV - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_dwell_cnt, w_dwell_nxt;
  logic [7:0] r_scan_cnt, w_scan_nxt;
  logic       r_digit, w_digit_nxt;
  logic [3:0] r_value, w_value_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_prio, w_prio_nxt;
  logic [7:0] r_seg, w_seg_nxt;
  logic [1:0] r_an, w_an_nxt;

  logic [1:0] w_grant;
  logic       w_window;
  logic       w_xfer;
  logic       w_xfer_idx;
  logic [7:0] w_sign_seg;
  logic [7:0] w_mag_seg;

  // r_prio names the requester that wins a tie.
  always_comb begin
    w_grant = req_valid;
    if (req_valid == 2'b11) begin
      w_grant = r_prio ? 2'b10 : 2'b01;
    end
  end

  assign w_window   = (r_state == ST_IDLE) ||
                      ((r_state == ST_SHOW) && (r_dwell_cnt == c_dwell_last));
  assign req_ready  = w_window ? w_grant : 2'b00;
  assign w_xfer     = |req_ready;
  assign w_xfer_idx = req_ready[1];

  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell_cnt;
    w_scan_nxt  = r_scan_cnt;
    w_digit_nxt = r_digit;
    w_value_nxt = r_value;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    if (w_xfer) begin
      w_state_nxt = ST_SHOW;
      w_dwell_nxt = 8'd0;
      w_scan_nxt  = 8'd0;
      w_digit_nxt = 1'b0;
      w_value_nxt = w_xfer_idx ? req_val1 : req_val0;
      w_owner_nxt = w_xfer_idx;
      w_prio_nxt  = ~w_xfer_idx;
    end else if (r_state == ST_SHOW) begin
      if (r_dwell_cnt == c_dwell_last) begin
        w_state_nxt = ST_IDLE;
        w_dwell_nxt = 8'd0;
        w_scan_nxt  = 8'd0;
        w_digit_nxt = 1'b0;
      end else begin
        w_dwell_nxt = r_dwell_cnt + 8'd1;
        if (r_scan_cnt == c_scan_last) begin
          w_scan_nxt  = 8'd0;
          w_digit_nxt = ~r_digit;
        end else begin
          w_scan_nxt = r_scan_cnt + 8'd1;
        end
      end
    end
  end

  // Encoding the next value lets the display register update on the transfer edge.
  seg_enc4 u_enc (
    .value    (w_value_nxt),
    .sign_seg (w_sign_seg),
    .mag_seg  (w_mag_seg)
  );

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = 2'b11;
    if (w_state_nxt == ST_SHOW) begin
      w_seg_nxt = w_digit_nxt ? w_sign_seg : w_mag_seg;
      w_an_nxt  = w_digit_nxt ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell_cnt <= 8'd0;
      r_scan_cnt  <= 8'd0;
      r_digit     <= 1'b0;
      r_value     <= 4'd0;
      r_owner     <= 1'b0;
      r_prio      <= 1'b0;
      r_seg       <= SEG_BLANK;
      r_an        <= 2'b11;
    end else begin
      r_dwell_cnt <= w_dwell_nxt;
      r_scan_cnt  <= w_scan_nxt;
      r_digit     <= w_digit_nxt;
      r_value     <= w_value_nxt;
      r_owner     <= w_owner_nxt;
      r_prio      <= w_prio_nxt;
      r_seg       <= w_seg_nxt;
      r_an        <= w_an_nxt;
    end
  end

  assign seg_out = r_seg;
  assign an_n    = r_an;
  assign owner   = r_owner;
  assign busy    = (r_state == ST_SHOW);

endmodule

`default_nettype wire

// File: tb/tb_seg_disp_arb.sv
// ============================================================================
// Module  : tb_seg_disp_arb
// Brief   : Directed self-checking bench for seg_disp_arb (DWELL 16, SCAN 4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_disp_arb;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [3:0] req_val0;
  logic [3:0] req_val1;
  logic [1:0] req_ready;
  logic [7:0] seg_out;
  logic [1:0] an_n;
  logic       owner;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  seg_disp_arb #(
    .DWELL_CYC (16),
    .SCAN_DIV  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_val0  (req_val0),
    .req_val1  (req_val1),
    .req_ready (req_ready),
    .seg_out   (seg_out),
    .an_n      (an_n),
    .owner     (owner),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_disp(input string tag, input logic [7:0] seg, input logic [1:0] an);
    chk({tag, ".seg"}, seg_out, seg);
    chk({tag, ".an"}, {6'd0, an_n}, {6'd0, an});
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_val0  = 4'd0;
    req_val1  = 4'd0;

    // Reset state
    step(1);
    chk_disp("rst", 8'hFF, 2'b11);
    chk("rst.busy", {7'd0, busy}, 8'd0);
    chk("rst.owner", {7'd0, owner}, 8'd0);
    chk("rst.ready", {6'd0, req_ready}, 8'd0);
    rst_n = 1'b1;

    // Requester 0, value -4: magnitude 4 then minus sign after 4 cycles
    req_valid = 2'b01;
    req_val0  = 4'b1100;
    #1;
    chk("t1.ready", {6'd0, req_ready}, 8'h01);
    step(1);
    req_valid = 2'b00;
    chk_disp("t1.k1", 8'h99, 2'b10);
    chk("t1.busy", {7'd0, busy}, 8'd1);
    chk("t1.owner", {7'd0, owner}, 8'd0);
    chk("t1.ready_show", {6'd0, req_ready}, 8'd0);
    step(3);
    chk_disp("t1.k4", 8'h99, 2'b10);
    step(1);
    chk_disp("t1.k5", 8'hFD, 2'b01);
    step(11);
    chk_disp("t1.k16", 8'hFD, 2'b01);
    chk("t1.k16.busy", {7'd0, busy}, 8'd1);
    step(1);
    chk_disp("t1.k17", 8'hFF, 2'b11);
    chk("t1.k17.busy", {7'd0, busy}, 8'd0);

    // Value -8 shows 8 with minus
    req_valid = 2'b01;
    req_val0  = 4'b1000;
    #1;
    chk("t2.ready", {6'd0, req_ready}, 8'h01);
    step(1);
    req_valid = 2'b00;
    chk_disp("t2.m8.mag", 8'h01, 2'b10);
    step(4);
    chk_disp("t2.m8.sign", 8'hFD, 2'b01);
    step(12);
    chk("t2.idle", {7'd0, busy}, 8'd0);

    // Requester 1, value +7
    req_valid = 2'b10;
    req_val1  = 4'b0111;
    #1;
    chk("t2.ready1", {6'd0, req_ready}, 8'h02);
    step(1);
    req_valid = 2'b00;
    chk_disp("t2.p7.mag", 8'h1F, 2'b10);
    chk("t2.p7.owner", {7'd0, owner}, 8'd1);
    step(4);
    chk_disp("t2.p7.sign", 8'hFF, 2'b01);
    step(12);

    // Both valid: round-robin every 16 cycles, back-to-back
    req_val0  = 4'd2;
    req_val1  = 4'd5;
    req_valid = 2'b11;
    #1;
    chk("t3.ready0", {6'd0, req_ready}, 8'h01);
    step(1);
    chk("t3.g0.owner", {7'd0, owner}, 8'd0);
    chk_disp("t3.g0", 8'h25, 2'b10);
    step(15);
    chk("t3.g0.last_ready", {6'd0, req_ready}, 8'h02);
    step(1);
    chk("t3.g1.owner", {7'd0, owner}, 8'd1);
    chk("t3.g1.busy", {7'd0, busy}, 8'd1);
    chk_disp("t3.g1", 8'h49, 2'b10);
    step(15);
    chk("t3.g1.last_ready", {6'd0, req_ready}, 8'h01);
    step(1);
    chk("t3.g2.owner", {7'd0, owner}, 8'd0);
    chk_disp("t3.g2", 8'h25, 2'b10);
    step(16);
    chk("t3.g3.owner", {7'd0, owner}, 8'd1);
    chk("t3.g3.busy", {7'd0, busy}, 8'd1);
    req_valid = 2'b00;
    step(16);
    chk("t3.idle", {7'd0, busy}, 8'd0);

    // Reset mid-SHOW after a requester-0 grant
    req_valid = 2'b01;
    req_val0  = 4'd1;
    step(1);
    req_valid = 2'b00;
    chk_disp("t4.k1", 8'h9F, 2'b10);
    step(6);
    chk("t4.k7.busy", {7'd0, busy}, 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_disp("t4.async", 8'hFF, 2'b11);
    chk("t4.async.busy", {7'd0, busy}, 8'd0);
    chk("t4.async.owner", {7'd0, owner}, 8'd0);
    #1;
    rst_n     = 1'b1;
    req_val0  = 4'd2;
    req_val1  = 4'd5;
    req_valid = 2'b11;
    #1;
    chk("t4.tie_ready", {6'd0, req_ready}, 8'h01);
    step(1);
    chk("t4.tie_owner", {7'd0, owner}, 8'd0);
    chk_disp("t4.tie", 8'h25, 2'b10);

    // Requester 1 value changes while showing: display holds
    req_valid = 2'b10;
    req_val1  = 4'd3;
    step(15);
    chk("t5.ready", {6'd0, req_ready}, 8'h02);
    step(1);
    chk("t5.owner", {7'd0, owner}, 8'd1);
    chk_disp("t5.k1", 8'h0D, 2'b10);
    req_valid = 2'b00;
    req_val1  = 4'd5;
    step(1);
    chk_disp("t5.k2", 8'h0D, 2'b10);
    step(3);
    chk_disp("t5.k5", 8'hFF, 2'b01);
    step(4);
    chk_disp("t5.k9", 8'h0D, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
